// File: rtl/bwn_conv_pkg.sv
// Shared types and constants for the binary-weight 3x3 convolution sequencer.
package bwn_conv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD  = 3'd1,
        WLATCH = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4,
        NEXT   = 3'd5
    } conv_state_e;

    localparam int CONV_PIPE_LAT = 3;
    localparam int KERNEL        = 3;
    localparam int BWN_W_BITS    = 9;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/bwn_scan_cnt.sv
// Raster row/col/address counter for one feature-map pass; wraps to zero after the last pixel.
module bwn_scan_cnt #(
    parameter int IMG_W  = 20,
    parameter int IMG_H  = 20,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 5,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ROW_W-1:0]  row_q,  row_d;
    logic [COL_W-1:0]  col_q,  col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              col_wrap_s;
    logic              last_s;

    assign col_wrap_s = (col_q == COL_W'(IMG_W - 1));
    assign last_s     = col_wrap_s && (row_q == ROW_W'(IMG_H - 1));

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clr_i || (en_i && last_s)) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (en_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_wrap_s) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign addr_o = addr_q;
    assign last_o = last_s;

endmodule

// File: rtl/bwn_conv_ctrl.sv
// Frame sequencer for the BWN 3x3 conv datapath: weight fetch, raster pixel reads, result tagging.
// Build option BWN_CONV_CTRL_STRIDE2_EN keeps only even-offset windows (stride-2 output grid).
module bwn_conv_ctrl
    import bwn_conv_pkg::*;
#(
    parameter int WL     = 8,
    parameter int IMG_W  = 20,
    parameter int IMG_H  = 20,
    parameter int NUM_CH = 8,
    parameter int PIX_AW = $clog2(IMG_W * IMG_H),
    parameter int CH_W   = clog2_min1(NUM_CH),
    parameter int OROW_W = clog2_min1(IMG_H - 2),
    parameter int OCOL_W = clog2_min1(IMG_W - 2)
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSTART,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic [PIX_AW-1:0]     oPIX_ADDR,
    output logic                  oPIX_RD,
    output logic [CH_W-1:0]       oW_ADDR,
    output logic                  oW_RD,
    input  logic [BWN_W_BITS-1:0] iW_DATA,
    output logic                  oCONV_START,
    output logic [BWN_W_BITS-1:0] oCONV_WEIGHT,
    output logic                  oOUT_VALID,
    output logic [CH_W-1:0]       oOUT_CH,
    output logic [OROW_W-1:0]     oOUT_ROW,
    output logic [OCOL_W-1:0]     oOUT_COL
);

    localparam int R_W     = clog2_min1(IMG_H);
    localparam int C_W     = clog2_min1(IMG_W);
    localparam int FLUSH_W = clog2_min1(CONV_PIPE_LAT);

    if ((WL < 1) || (IMG_W < KERNEL) || (IMG_H < KERNEL) || (NUM_CH < 1)) begin : g_bad_cfg
        $error("bwn_conv_ctrl: unsupported configuration");
    end

    typedef struct packed {
        logic              valid;
        logic [CH_W-1:0]   ch;
        logic [OROW_W-1:0] row;
        logic [OCOL_W-1:0] col;
    } tag_t;

    conv_state_e           state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [FLUSH_W-1:0]    flush_q, flush_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  w_rd_q, w_rd_d;
    logic                  pix_rd_q, pix_rd_d;
    logic                  start_q, start_d;
    logic [BWN_W_BITS-1:0] weight_q, weight_d;
    logic                  scan_clr_s, scan_en_s, scan_last_s;
    logic [R_W-1:0]        row_s, row_off_s;
    logic [C_W-1:0]        col_s, col_off_s;
    logic [PIX_AW-1:0]     addr_s;
    tag_t                  tag_d;
    tag_t                  pipe_q [CONV_PIPE_LAT];

    bwn_scan_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ROW_W  (R_W),
        .COL_W  (C_W),
        .ADDR_W (PIX_AW)
    ) u_scan (
        .clk_i  (iCLK),
        .rst_ni (iRST),
        .clr_i  (scan_clr_s),
        .en_i   (scan_en_s),
        .row_o  (row_s),
        .col_o  (col_s),
        .addr_o (addr_s),
        .last_o (scan_last_s)
    );

    // Next-state and registered-output decode; outputs are set on the transition into a state.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        flush_d    = flush_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        w_rd_d     = 1'b0;
        start_d    = start_q;
        weight_d   = weight_q;
        scan_clr_s = 1'b0;
        scan_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    state_d = WLOAD;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    w_rd_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WLOAD: begin
                state_d = WLATCH;
            end
            WLATCH: begin
                weight_d   = iW_DATA;
                start_d    = 1'b1;
                scan_clr_s = 1'b1;
                state_d    = STREAM;
            end
            STREAM: begin
                scan_en_s = 1'b1;
                if (scan_last_s) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end else begin
                    state_d = STREAM;
                end
            end
            FLUSH: begin
                if (flush_q == FLUSH_W'(CONV_PIPE_LAT - 1)) begin
                    state_d = NEXT;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        start_d = 1'b0;
                    end else begin
                        done_d = 1'b0;
                    end
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            NEXT: begin
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    w_rd_d  = 1'b1;
                    state_d = WLOAD;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                start_d = 1'b0;
            end
        endcase
        pix_rd_d = (state_d == STREAM);
    end

    // FSM state and registered control outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            flush_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            w_rd_q   <= 1'b0;
            pix_rd_q <= 1'b0;
            start_q  <= 1'b0;
            weight_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            flush_q  <= flush_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            w_rd_q   <= w_rd_d;
            pix_rd_q <= pix_rd_d;
            start_q  <= start_d;
            weight_q <= weight_d;
        end
    end

    // Windows whose bottom-right pixel lies at r>=2, c>=2 are complete and belong to this pass.
    always_comb begin
        tag_d     = '0;
        row_off_s = row_s - R_W'(KERNEL - 1);
        col_off_s = col_s - C_W'(KERNEL - 1);
        if ((state_q == STREAM) && (row_s >= R_W'(KERNEL - 1)) && (col_s >= C_W'(KERNEL - 1))) begin
`ifdef BWN_CONV_CTRL_STRIDE2_EN
            tag_d.valid = !row_off_s[0] && !col_off_s[0];
            tag_d.row   = tag_d.valid ? OROW_W'(row_off_s >> 1) : '0;
            tag_d.col   = tag_d.valid ? OCOL_W'(col_off_s >> 1) : '0;
`else
            tag_d.valid = 1'b1;
            tag_d.row   = OROW_W'(row_off_s);
            tag_d.col   = OCOL_W'(col_off_s);
`endif
            tag_d.ch    = tag_d.valid ? ch_q : '0;
        end else begin
            tag_d = '0;
        end
    end

    // Tag pipeline matching RAM latency, window register and output register.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            for (int i = 0; i < CONV_PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_d;
            for (int i = 1; i < CONV_PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign oBUSY        = busy_q;
    assign oDONE        = done_q;
    assign oPIX_ADDR    = addr_s;
    assign oPIX_RD      = pix_rd_q;
    assign oW_ADDR      = ch_q;
    assign oW_RD        = w_rd_q;
    assign oCONV_START  = start_q;
    assign oCONV_WEIGHT = weight_q;
    assign oOUT_VALID   = pipe_q[CONV_PIPE_LAT-1].valid;
    assign oOUT_CH      = pipe_q[CONV_PIPE_LAT-1].ch;
    assign oOUT_ROW     = pipe_q[CONV_PIPE_LAT-1].row;
    assign oOUT_COL     = pipe_q[CONV_PIPE_LAT-1].col;

endmodule

// File: tb/tb_bwn_conv_ctrl.sv
// Self-checking bench for bwn_conv_ctrl (2 channels, 20x20 map) against a cycle-index arithmetic model.
module tb_bwn_conv_ctrl;

    localparam int W     = 20;
    localparam int H     = 20;
    localparam int NCH   = 2;
    localparam int NPIX  = W * H;
    localparam int CPC   = NPIX + 6;
    localparam int TOTAL = NCH * CPC;
    localparam int AW    = $clog2(NPIX);
    localparam int CW    = 1;
    localparam int RW    = $clog2(H - 2);
    localparam int CLW   = $clog2(W - 2);
`ifdef BWN_CONV_CTRL_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int EXP_PER_CH  = ((H - 2 + STRIDE - 1) / STRIDE) * ((W - 2 + STRIDE - 1) / STRIDE);
    localparam int EXP_MAX_ROW = (H - 3) / STRIDE;
    localparam int EXP_MAX_COL = (W - 3) / STRIDE;
    localparam int FIRST_ADDR  = 2 * W + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [8:0]     w_data = 9'd0;
    logic           busy, done, pix_rd, w_rd, conv_start, out_valid;
    logic [AW-1:0]  pix_addr;
    logic [CW-1:0]  w_addr, out_ch;
    logic [8:0]     weight;
    logic [RW-1:0]  out_row;
    logic [CLW-1:0] out_col;
    logic [8:0]     rom [NCH];

    int n_checks = 0;
    int n_fail   = 0;

    bwn_conv_ctrl #(
        .WL(8), .IMG_W(W), .IMG_H(H), .NUM_CH(NCH)
    ) dut (
        .iCLK(clk), .iRST(rst_n), .iSTART(start),
        .oBUSY(busy), .oDONE(done),
        .oPIX_ADDR(pix_addr), .oPIX_RD(pix_rd),
        .oW_ADDR(w_addr), .oW_RD(w_rd), .iW_DATA(w_data),
        .oCONV_START(conv_start), .oCONV_WEIGHT(weight),
        .oOUT_VALID(out_valid), .oOUT_CH(out_ch),
        .oOUT_ROW(out_row), .oOUT_COL(out_col)
    );

    always #5 clk = ~clk;

    // Weight ROM with one cycle of read latency
    always @(posedge clk) begin
        if (w_rd === 1'b1) w_data <= rom[w_addr];
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, pix_addr, pix_rd, w_addr, w_rd, conv_start, weight,
             out_valid, out_ch, out_row, out_col} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b addr=%0d rd=%b wrd=%b start=%b wgt=%h valid=%b, want all 0",
                     busy, done, pix_addr, pix_rd, w_rd, conv_start, weight, out_valid);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || w_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: got busy=%b w_rd=%b, want 0 0", busy, w_rd);
        end
    endtask

    task automatic run_frame(input string name, input bit noise);
        int    err_ctl, err_pix, err_val, err_wgt, done_cnt, done_k, first_v, max_row, max_col;
        int    vcnt [NCH];
        int    addr_at [TOTAL+4];
        string m_ctl, m_pix, m_val, m_wgt;
        err_ctl = 0; err_pix = 0; err_val = 0; err_wgt = 0;
        done_cnt = 0; done_k = -1; first_v = -1; max_row = 0; max_col = 0;
        m_ctl = ""; m_pix = ""; m_val = ""; m_wgt = "";
        foreach (vcnt[i]) vcnt[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < TOTAL + 4; k++) begin
            bit in_f, e_busy, e_done, e_wrd, e_prd, e_start, e_v;
            int ch, kk, p, r, c, e_row, e_col, wch;
            in_f    = (k < TOTAL);
            ch      = in_f ? k / CPC : NCH - 1;
            kk      = in_f ? k % CPC : CPC;
            e_busy  = (k < TOTAL - 1);
            e_done  = (k == TOTAL - 1);
            e_wrd   = in_f && (kk == 0);
            e_prd   = in_f && (kk >= 2) && (kk < 2 + NPIX);
            e_start = (k >= 2) && (k < TOTAL - 1);
            e_v = 1'b0; e_row = 0; e_col = 0;
            if (in_f && kk >= 5 && kk < 5 + NPIX) begin
                p = kk - 5; r = p / W; c = p % W;
                if (r >= 2 && c >= 2 && (r - 2) % STRIDE == 0 && (c - 2) % STRIDE == 0) begin
                    e_v = 1'b1; e_row = (r - 2) / STRIDE; e_col = (c - 2) / STRIDE;
                end
            end
            addr_at[k] = int'(pix_addr);
            if ({busy, done, w_rd, pix_rd, conv_start} !== {e_busy, e_done, e_wrd, e_prd, e_start} ||
                (e_wrd && w_addr !== CW'(ch))) begin
                err_ctl++;
                if (err_ctl == 1) m_ctl = $sformatf("k=%0d got busy/done/wrd/prd/start=%b%b%b%b%b waddr=%0d want %b%b%b%b%b waddr=%0d",
                    k, busy, done, w_rd, pix_rd, conv_start, w_addr, e_busy, e_done, e_wrd, e_prd, e_start, ch);
            end
            if (e_prd && pix_addr !== AW'(kk - 2)) begin
                err_pix++;
                if (err_pix == 1) m_pix = $sformatf("k=%0d got addr=%0d want %0d", k, pix_addr, kk - 2);
            end
            if (out_valid !== e_v ||
                (e_v && {out_ch, out_row, out_col} !== {CW'(ch), RW'(e_row), CLW'(e_col)})) begin
                err_val++;
                if (err_val == 1) m_val = $sformatf("k=%0d got v=%b ch=%0d r=%0d c=%0d want v=%b ch=%0d r=%0d c=%0d",
                    k, out_valid, out_ch, out_row, out_col, e_v, ch, e_row, e_col);
            end
            if (k >= 2) begin
                wch = (k - 2) / CPC;
                if (wch > NCH - 1) wch = NCH - 1;
                if (weight !== rom[wch]) begin
                    err_wgt++;
                    if (err_wgt == 1) m_wgt = $sformatf("k=%0d got %h want %h", k, weight, rom[wch]);
                end
            end
            if (done === 1'b1) begin done_cnt++; done_k = k; end
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = k;
                vcnt[int'(out_ch)]++;
                if (int'(out_row) > max_row) max_row = int'(out_row);
                if (int'(out_col) > max_col) max_col = int'(out_col);
            end
            start = (noise && k >= 2 && k <= TOTAL - 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
        end
        n_checks++;
        if (err_ctl != 0) begin n_fail++; $display("FAIL %s ctrl_seq: %0d errors, first %s", name, err_ctl, m_ctl); end
        n_checks++;
        if (err_pix != 0) begin n_fail++; $display("FAIL %s pix_addr_seq: %0d errors, first %s", name, err_pix, m_pix); end
        n_checks++;
        if (err_val != 0) begin n_fail++; $display("FAIL %s out_tag_seq: %0d errors, first %s", name, err_val, m_val); end
        n_checks++;
        if (err_wgt != 0) begin n_fail++; $display("FAIL %s weight_stable: %0d errors, first %s", name, err_wgt, m_wgt); end
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (vcnt[i] != EXP_PER_CH) begin
                n_fail++; $display("FAIL %s valid_count_ch%0d: got %0d want %0d", name, i, vcnt[i], EXP_PER_CH);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_k + 1 != NCH * CPC) begin
            n_fail++; $display("FAIL %s done_timing: got %0d pulses at cycle %0d want 1 at %0d", name, done_cnt, done_k + 1, NCH * CPC);
        end
        n_checks++;
        if (first_v != 2 + FIRST_ADDR + 3 || first_v < 3 || addr_at[(first_v < 3) ? 0 : first_v - 3] != FIRST_ADDR) begin
            n_fail++; $display("FAIL %s first_valid: got cycle %0d want %0d (addr %0d issued 3 cycles earlier)",
                               name, first_v, 2 + FIRST_ADDR + 3, FIRST_ADDR);
        end
        n_checks++;
        if (max_row != EXP_MAX_ROW || max_col != EXP_MAX_COL) begin
            n_fail++; $display("FAIL %s coord_range: got max row %0d col %0d want %0d %0d", name, max_row, max_col, EXP_MAX_ROW, EXP_MAX_COL);
        end
    endtask

    task automatic test_reset_mid_pass();
        int bad;
        bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2 + 150) tick();
        n_checks++;
        if (pix_addr !== AW'(150) || pix_rd !== 1'b1) begin
            n_fail++; $display("FAIL midreset_position: got addr=%0d rd=%b want 150 1", pix_addr, pix_rd);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({busy, out_valid, done, pix_rd, conv_start} !== 5'b0 || weight !== 9'd0) begin
            n_fail++; $display("FAIL midreset_abort: got busy=%b valid=%b done=%b rd=%b start=%b wgt=%h want all 0",
                               busy, out_valid, done, pix_rd, conv_start, weight);
        end
        for (int i = 0; i < 2 * CPC; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d busy/done cycles want 0", bad); end
    endtask

    initial begin
        rom[0] = 9'h1FF;
        rom[1] = 9'h000;
        test_reset();
        run_frame("frame_basic", 1'b0);
        test_reset_mid_pass();
        for (int i = 0; i < NCH; i++) rom[i] = 9'($urandom);
        run_frame("frame_after_abort", 1'b0);
        for (int i = 0; i < NCH; i++) rom[i] = 9'($urandom);
        run_frame("start_noise", 1'b1);
        run_frame("back_to_back", 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
